set_scan_ctrl: RTL and testbench

//   Controller on the driving side of the PE coverage interface. Latches one job
//   (three circle centres, radii and a mode), sweeps every grid point (1..8, 1..8)

---
 rtl/set_scan_ctrl.sv | 107 ++++++++++
 tb/tb_set_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/set_scan_ctrl.sv
// Drives the PE coverage interface: latches one job, rasters the grid through the PE
// and counts points whose coverage bits satisfy the selected predicate.
module set_scan_ctrl #(
    parameter int unsigned GRID_MIN = 1,
    parameter int unsigned GRID_MAX = 8,
    parameter int unsigned CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [23:0]      central_i,
    input  logic [11:0]      radius_i,
    input  logic [1:0]       mode_i,
    input  logic [2:0]       covered_i,
    output logic [7:0]       coord_o,
    output logic [23:0]      cent_buf_o,
    output logic [11:0]      r_buf_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] candidate_o
);

    localparam logic [3:0] GMin = 4'(GRID_MIN);
    localparam logic [3:0] GMax = 4'(GRID_MAX);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e     state_q;
    logic [1:0] mode_q;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic       hit;
    logic       cov_a;
    logic       cov_b;
    logic       cov_c;

    assign cov_a   = covered_i[2];
    assign cov_b   = covered_i[1];
    assign cov_c   = covered_i[0];
    assign coord_o = {x_q, y_q};

    always_comb begin
        hit = 1'b0;
        unique case (mode_q)
            2'd0: hit = cov_a;
            2'd1: hit = cov_a & cov_b;
            2'd2: hit = cov_a ^ cov_b;
            2'd3: hit = (cov_a & cov_b & ~cov_c) | (cov_a & ~cov_b & cov_c) |
                        (~cov_a & cov_b & cov_c);
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 2'd0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            cent_buf_o  <= 24'd0;
            r_buf_o     <= 12'd0;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            candidate_o <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    if (en_i) begin
                        cent_buf_o  <= central_i;
                        r_buf_o     <= radius_i;
                        mode_q      <= mode_i;
                        x_q         <= GMin;
                        y_q         <= GMin;
                        candidate_o <= '0;
                        busy_o      <= 1'b1;
                        state_q     <= StScan;
                    end
                end
                StScan: begin
                    if (hit) begin
                        candidate_o <= candidate_o + CNT_W'(1);
                    end
                    // Last point leaves coord_o parked at (GRID_MAX, GRID_MAX).
                    if (x_q == GMax) begin
                        if (y_q == GMax) begin
                            state_q <= StDone;
                        end else begin
                            x_q <= GMin;
                            y_q <= y_q + 4'd1;
                        end
                    end else begin
                        x_q <= x_q + 4'd1;
                    end
                end
                StDone: begin
                    // busy_o stays high across the valid pulse; IDLE drops both.
                    valid_o <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Self-checking bench for set_scan_ctrl with a behavioural three-circle PE model.
module tb_set_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [23:0] central_i;
    logic [11:0] radius_i;
    logic [1:0]  mode_i;
    logic [2:0]  covered_i;
    logic [7:0]  coord_o;
    logic [23:0] cent_buf_o;
    logic [11:0] r_buf_o;
    logic        busy_o;
    logic        valid_o;
    logic [6:0]  candidate_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    set_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .central_i  (central_i),
        .radius_i   (radius_i),
        .mode_i     (mode_i),
        .covered_i  (covered_i),
        .coord_o    (coord_o),
        .cent_buf_o (cent_buf_o),
        .r_buf_o    (r_buf_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .candidate_o(candidate_o)
    );

    function automatic logic in_circ(input int x, input int y, input int cx, input int cy,
                                     input int r);
        int dx;
        int dy;
        dx = x - cx;
        dy = y - cy;
        return (dx * dx + dy * dy) <= (r * r);
    endfunction

    // PE: point inside or on each circle, fed from the controller's buffers.
    always_comb begin
        covered_i[2] = in_circ(int'(coord_o[7:4]), int'(coord_o[3:0]),
                               int'(cent_buf_o[23:20]), int'(cent_buf_o[19:16]),
                               int'(r_buf_o[11:8]));
        covered_i[1] = in_circ(int'(coord_o[7:4]), int'(coord_o[3:0]),
                               int'(cent_buf_o[15:12]), int'(cent_buf_o[11:8]),
                               int'(r_buf_o[7:4]));
        covered_i[0] = in_circ(int'(coord_o[7:4]), int'(coord_o[3:0]),
                               int'(cent_buf_o[7:4]), int'(cent_buf_o[3:0]),
                               int'(r_buf_o[3:0]));
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Accept edge k is the first posedge after this task starts.
    task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input int exp, input bit hold);
        int ex;
        int ey;
        @(negedge clk);
        central_i = c;
        radius_i  = r;
        mode_i    = m;
        en_i      = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_busy", int'(busy_o), 1);
        chk("accept_coord", int'(coord_o), 8'h11);
        chk("accept_cand", int'(candidate_o), 0);
        chk("accept_cent", int'(cent_buf_o), int'(c));
        @(negedge clk);
        if (!hold) en_i = 1'b0;
        central_i = ~c;
        radius_i  = ~r;
        mode_i    = m + 2'd1;
        for (int i = 1; i < 64; i++) begin
            @(posedge clk);
            #1;
            ex = 1 + (i % 8);
            ey = 1 + (i / 8);
            chk("raster_coord", int'(coord_o), (ex << 4) | ey);
            chk("scan_valid_low", int'(valid_o), 0);
        end
        @(posedge clk);
        #1;
        chk("done_coord", int'(coord_o), 8'h88);
        chk("done_valid_low", int'(valid_o), 0);
        chk("done_busy", int'(busy_o), 1);
        @(posedge clk);
        #1;
        chk("valid_pulse", int'(valid_o), 1);
        chk("valid_busy", int'(busy_o), 1);
        chk("candidate", int'(candidate_o), exp);
        chk("rbuf_stable", int'(r_buf_o), int'(r));
    endtask

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        int          exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{24'h440000, 12'h200, 2'd0, 13};
        vecs[1] = '{24'h110000, 12'hF00, 2'd0, 64};
        vecs[2] = '{24'h440000, 12'h000, 2'd0, 1};
        vecs[3] = '{24'h227700, 12'h110, 2'd1, 0};
        vecs[4] = '{24'h444400, 12'h220, 2'd2, 0};
        vecs[5] = '{24'h444488, 12'h220, 2'd3, 13};
        vecs[6] = '{24'h444444, 12'h222, 2'd3, 0};
        vecs[7] = '{24'h445400, 12'h200, 2'd1, 1};
        vecs[8] = '{24'h118800, 12'h100, 2'd2, 4};
        vecs[9] = '{24'h444400, 12'h220, 2'd1, 13};

        rst       = 1'b1;
        en_i      = 1'b0;
        central_i = 24'hABCDEF;
        radius_i  = 12'h123;
        mode_i    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_coord", int'(coord_o), 0);
        chk("rst_cent", int'(cent_buf_o), 0);
        chk("rst_rbuf", int'(r_buf_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_cand", int'(candidate_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy_o), 0);

        for (int v = 0; v < 10; v++) begin
            run_job(vecs[v].c, vecs[v].r, vecs[v].m, vecs[v].exp, 1'b0);
            @(posedge clk);
            #1;
            chk("post_valid_low", int'(valid_o), 0);
            chk("post_busy_low", int'(busy_o), 0);
            chk("post_cand_hold", int'(candidate_o), vecs[v].exp);
        end

        // en_i held high: one job, then the next starts on the first IDLE edge.
        run_job(24'h440000, 12'h200, 2'd0, 13, 1'b1);
        run_job(24'h110000, 12'hF00, 2'd0, 64, 1'b1);
        @(negedge clk);
        en_i = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_valid_low", int'(valid_o), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle_busy", int'(busy_o), 0);

        // Reset during SCAN aborts the job with no valid pulse.
        @(negedge clk);
        central_i = 24'h440000;
        radius_i  = 12'h200;
        mode_i    = 2'd0;
        en_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_i = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_coord", int'(coord_o), 0);
        chk("abort_cent", int'(cent_buf_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_valid", int'(valid_o), 0);
        chk("abort_cand", int'(candidate_o), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
                chk("abort_no_valid", int'({busy_o, valid_o}), 0);
            end
        end
        chk("abort_idle_valid", int'(valid_o), 0);
        run_job(24'h444488, 12'h220, 2'd3, 13, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
